// File: rtl/io_timer.sv
// io_timer: memory-mapped 16-bit down-counting timer on the CPU I/O data bus.
// Register window BASEADDR..BASEADDR+15 (little-endian 16-bit registers):
//   0x0 CTRL {IE,AR,EN}, 0x2 RELOAD, 0x4 COUNT, 0x6 STATUS {EXP, write-1-clear},
//   0x8 PRESCALE, 0xA-0xE reserved (read 0, writes ignored).
// Ports:
//   clk          - single clock, rising edge
//   reset        - asynchronous active-low reset
//   dread_addr   - read byte address (cycle N)
//   dread_data   - registered read data for cycle N's address (cycle N+1)
//   dwrite_addr  - write byte address
//   dwrite_data  - write data, [7:0] to addr, [15:8] to addr+1
//   dwrite_en    - byte-lane write enables
//   interrupt    - registered level interrupt, EXP & IE
module io_timer #(
  parameter logic [15:0] BASEADDR = 16'h0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dread_addr,
  output logic [15:0] dread_data,
  input  logic [15:0] dwrite_addr,
  input  logic [15:0] dwrite_data,
  input  logic [1:0]  dwrite_en,
  output logic        interrupt
);

  localparam int unsigned DW     = 16;
  localparam int unsigned NBYTES = 16;
  localparam int unsigned IMGW   = NBYTES * 8;
  localparam int unsigned CTRLW  = 3;

  // Architectural state
  logic [CTRLW-1:0] ctrl;
  logic [DW-1:0]    reload;
  logic [DW-1:0]    count;
  logic             expired;
  logic [DW-1:0]    prescale;
  logic [DW-1:0]    pcnt;

  // Next-state values
  logic [CTRLW-1:0] ctrl_n;
  logic [DW-1:0]    reload_n;
  logic [DW-1:0]    count_n;
  logic             expired_n;
  logic [DW-1:0]    prescale_n;
  logic [DW-1:0]    pcnt_n;
  logic [DW-1:0]    rdata_n;
  logic             irq_n;

  // Byte addresses of each lane and their window hits
  logic [DW-1:0] wa0, wa1, ra0, ra1;
  logic          hit_w0, hit_w1, hit_r0, hit_r1;

  assign wa0 = dwrite_addr;
  assign wa1 = dwrite_addr + 16'd1;
  assign ra0 = dread_addr;
  assign ra1 = dread_addr + 16'd1;

  assign hit_w0 = (wa0[15:4] == BASEADDR[15:4]);
  assign hit_w1 = (wa1[15:4] == BASEADDR[15:4]);
  assign hit_r0 = (ra0[15:4] == BASEADDR[15:4]);
  assign hit_r1 = (ra1[15:4] == BASEADDR[15:4]);

  // Per-byte write strobes and data across the 16-byte window
  logic [NBYTES-1:0] byte_we;
  logic [IMGW-1:0]   byte_wd;

  always_comb begin
    byte_we = '0;
    byte_wd = '0;
    if (dwrite_en[0] && hit_w0) begin
      byte_we[wa0[3:0]]                 = 1'b1;
      byte_wd[{wa0[3:0], 3'b000} +: 8] = dwrite_data[7:0];
    end
    if (dwrite_en[1] && hit_w1) begin
      byte_we[wa1[3:0]]                 = 1'b1;
      byte_wd[{wa1[3:0], 3'b000} +: 8] = dwrite_data[15:8];
    end
  end

  // Current register image, byte i of the window at bits [8i+7:8i]
  logic [IMGW-1:0] img;
  assign img = {48'h0, prescale, 15'h0, expired, count, reload, 13'h0, ctrl};

  logic [7:0] rbyte0, rbyte1;
  assign rbyte0 = hit_r0 ? img[{ra0[3:0], 3'b000} +: 8] : 8'h00;
  assign rbyte1 = hit_r1 ? img[{ra1[3:0], 3'b000} +: 8] : 8'h00;

  // Bytes that have no storage behind them
  logic unused_bits;
  assign unused_bits = ^{byte_we[15:10], byte_we[7], byte_we[1],
                         byte_wd[127:80], byte_wd[63:49], byte_wd[15:3]};

  logic en, ar, ie;
  logic tick, expire;
  logic count_wr;

  assign en       = ctrl[0];
  assign ar       = ctrl[1];
  assign ie       = ctrl[2];
  assign tick     = en && (pcnt == 16'd0);
  assign expire   = tick && (count == 16'd0);
  assign count_wr = byte_we[4] || byte_we[5];

  // Next-state logic
  always_comb begin
    ctrl_n     = ctrl;
    reload_n   = reload;
    count_n    = count;
    expired_n  = expired;
    prescale_n = prescale;
    pcnt_n     = pcnt;
    rdata_n    = {rbyte1, rbyte0};
    irq_n      = expired && ie;

    // One-shot expiry clears EN; a CPU write to CTRL in the same cycle wins
    if (expire && !ar) ctrl_n[0] = 1'b0;
    if (byte_we[0]) ctrl_n = byte_wd[2:0];

    if (byte_we[2]) reload_n[7:0]  = byte_wd[23:16];
    if (byte_we[3]) reload_n[15:8] = byte_wd[31:24];

    // CPU write replaces the tick update; unwritten byte keeps its pre-tick value
    if (count_wr) begin
      if (byte_we[4]) count_n[7:0]  = byte_wd[39:32];
      if (byte_we[5]) count_n[15:8] = byte_wd[47:40];
    end else if (tick) begin
      if (count != 16'd0) count_n = count - 16'd1;
      else if (ar)        count_n = reload;
    end

    // Expiry set is applied after the clear so it wins a same-cycle collision
    if (byte_we[6] && byte_wd[48]) expired_n = 1'b0;
    if (expire) expired_n = 1'b1;

    if (byte_we[8]) prescale_n[7:0]  = byte_wd[71:64];
    if (byte_we[9]) prescale_n[15:8] = byte_wd[79:72];

    // Held at PRESCALE while disabled, so a 0->1 EN write starts a full period
    if (!en || (pcnt == 16'd0)) pcnt_n = prescale;
    else                        pcnt_n = pcnt - 16'd1;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl       <= '0;
      reload     <= '0;
      count      <= '0;
      expired    <= 1'b0;
      prescale   <= '0;
      pcnt       <= '0;
      dread_data <= '0;
      interrupt  <= 1'b0;
    end else begin
      ctrl       <= ctrl_n;
      reload     <= reload_n;
      count      <= count_n;
      expired    <= expired_n;
      prescale   <= prescale_n;
      pcnt       <= pcnt_n;
      dread_data <= rdata_n;
      interrupt  <= irq_n;
    end
  end

endmodule
